dr_uart_dump: RTL and testbench

Serial debug monitor that sits directly downstream of the CPU top's `dr` output (the 32-bit debug register written by CPDR). Whenever `dr` changes, or software-independent `dump` is pulsed, it transmits the value over an 8N1 UART as eight uppercase ASCII hex digits followed by CR LF. A one-entry pending slot absorbs changes that arrive mid-frame, and an overrun counter records values lost.

---
 rtl/dr_uart_dump.sv | 157 +++++++++++++++
 tb/tb_dr_uart_dump.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_uart_dump.sv
// rtl/dr_uart_dump.sv - UART hex dump of the CPU debug register (8N1, "XXXXXXXX\r\n")
module dr_uart_dump #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dr,
    input  logic        dump,
    output logic        txd,
    output logic        busy,
    output logic [7:0]  overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [3:0]  char_idx_q, char_idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] last_dr_q, last_dr_d;
    logic [7:0]  overrun_q, overrun_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;

    logic        ev;
    logic        bit_done;
    logic [7:0]  cur_byte;

    function automatic logic [7:0] char_code(input logic [31:0] word, input logic [3:0] idx);
        logic [31:0] sh;
        logic [3:0]  nib;
        sh  = word >> (5'd28 - {idx[2:0], 2'b00});
        nib = sh[3:0];
        if (idx == 4'd8)
            char_code = 8'h0D;
        else if (idx == 4'd9)
            char_code = 8'h0A;
        else if (nib < 4'd10)
            char_code = 8'h30 + {4'h0, nib};
        else
            char_code = 8'h37 + {4'h0, nib};
    endfunction

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        overrun_d  = overrun_q;
        last_dr_d  = dr;

        ev       = (dr != last_dr_q) || dump;
        bit_done = (baud_cnt_q == BAUD_MAX);

        if (state_q == S_IDLE) begin
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            char_idx_d = '0;
            if (pend_v_q) begin
                // Pending value goes out first; a simultaneous event refills the slot.
                shadow_d = pend_q;
                pend_v_d = ev;
                if (ev) pend_d = dr;
                state_d = S_START;
            end else if (ev) begin
                shadow_d = dr;
                state_d  = S_START;
            end
        end else begin
            if (ev) begin
                pend_d   = dr;
                pend_v_d = 1'b1;
                if (pend_v_q && overrun_q != 8'hFF)
                    overrun_d = overrun_q + 8'd1;
            end
            baud_cnt_d = bit_done ? 16'd0 : baud_cnt_q + 16'd1;
            if (bit_done) begin
                case (state_q)
                    S_START: begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                    S_DATA: begin
                        if (bit_idx_q == 3'd7)
                            state_d = S_STOP;
                        else
                            bit_idx_d = bit_idx_q + 3'd1;
                    end
                    default: begin
                        if (char_idx_q == 4'd9) begin
                            char_idx_d = '0;
                            state_d    = S_IDLE;
                        end else begin
                            char_idx_d = char_idx_q + 4'd1;
                            state_d    = S_START;
                        end
                    end
                endcase
            end
        end

        // Outputs are registered from the next state so they change on the same edge.
        cur_byte = char_code(shadow_d, char_idx_d);
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = cur_byte[bit_idx_d];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            char_idx_q <= '0;
            shadow_q   <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            last_dr_q  <= '0;
            overrun_q  <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            last_dr_q  <= last_dr_d;
            overrun_q  <= overrun_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_dr_uart_dump.sv
// tb/tb_dr_uart_dump.sv - scoreboard bench for dr_uart_dump with a UART receive model
module tb_dr_uart_dump;

    localparam int CPB = 4;

    logic        clk;
    logic        reset;
    logic [31:0] dr;
    logic        dump;
    logic        txd;
    logic        busy;
    logic [7:0]  overrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];

    dr_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset   (reset),
        .dr      (dr),
        .dump    (dump),
        .txd     (txd),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n <= 4'd9) return 8'd48 + 8'(n);
        return 8'd65 + 8'(n) - 8'd10;
    endfunction

    task automatic push_frame(input logic [31:0] v);
        for (int k = 0; k < 8; k++)
            exp_q.push_back(hex_ascii(v[31 - 4*k -: 4]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Receiver samples each bit mid-cell on falling clock edges
    int         mon_cnt = 0;
    bit         mon_act = 0;
    logic [7:0] rx_byte;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (reset) begin
            mon_act = 0;
        end else if (!mon_act) begin
            if (txd == 1'b0) begin
                mon_act = 1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % CPB) == 0)
                rx_byte[(mon_cnt - 6) / CPB] = txd;
            if (mon_cnt == 38) begin
                chk("stop_bit", {31'd0, txd}, 32'd1);
                mon_act = 0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: got 0x%0h, expected no byte", rx_byte);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_b});
                end
            end
        end
    end

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: timeout, %0d bytes outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input logic [31:0] v);
        @(negedge clk);
        reset = 1'b1;
        dr    = v;
        dump  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0] dr;
        logic        dump;
        logic        frame;
        int          busy_cycles;
    } vec_t;

    vec_t vecs[6];
    int   bc;
    int   gap;

    initial begin
        vecs[0] = '{32'h1234ABCD, 1'b0, 1'b1, 400};
        vecs[1] = '{32'h1234ABCD, 1'b0, 1'b0, 0};
        vecs[2] = '{32'h1234ABCD, 1'b1, 1'b1, 400};
        vecs[3] = '{32'h00000000, 1'b0, 1'b1, 400};
        vecs[4] = '{32'hDEADBEEF, 1'b0, 1'b1, 400};
        vecs[5] = '{32'h9A0F5C6E, 1'b0, 1'b1, 400};

        reset = 1'b1;
        dr    = '0;
        dump  = 1'b0;
        #12;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_overrun", {24'd0, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dr   = vecs[i].dr;
            dump = vecs[i].dump;
            if (vecs[i].frame) push_frame(vecs[i].dr);
            @(posedge clk);
            #1;
            dump = 1'b0;
            bc = busy ? 1 : 0;
            for (int c = 0; c < 1000 && busy; c++) begin
                @(posedge clk);
                #1;
                if (busy) bc++;
            end
            chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].busy_cycles);
            wait_done();
            chk($sformatf("vec%0d_overrun", i), {24'd0, overrun}, 32'd0);
        end

        // Second dump mid-frame: identical frame after one idle cycle, no overrun
        do_reset(32'h0);
        @(negedge clk);
        dump = 1'b1;
        push_frame(32'h0);
        @(negedge clk);
        dump = 1'b0;
        repeat (50) @(negedge clk);
        dump = 1'b1;
        push_frame(32'h0);
        @(negedge clk);
        dump = 1'b0;
        for (int c = 0; c < 1000 && busy; c++) begin
            @(posedge clk);
            #1;
        end
        gap = 0;
        for (int c = 0; c < 20 && !busy; c++) begin
            gap++;
            @(posedge clk);
            #1;
        end
        chk("gap_cycles", gap, 1);
        wait_done();
        chk("dump_overrun", {24'd0, overrun}, 32'd0);

        // Three changes mid-frame: only the last is sent, two overruns
        do_reset(32'h0);
        @(negedge clk);
        dump = 1'b1;
        push_frame(32'h0);
        @(negedge clk);
        dump = 1'b0;
        repeat (20) @(negedge clk);
        dr = 32'h1;
        @(negedge clk);
        dr = 32'h2;
        @(negedge clk);
        dr = 32'h3;
        push_frame(32'h3);
        wait_done();
        chk("overrun_two", {24'd0, overrun}, 32'd2);

        // 300 overwrites saturate the counter
        do_reset(32'h0);
        @(negedge clk);
        dump = 1'b1;
        push_frame(32'h0);
        @(negedge clk);
        dump = 1'b0;
        for (int i = 1; i <= 301; i++) begin
            dr = 32'(i);
            @(negedge clk);
        end
        push_frame(32'd301);
        wait_done();
        chk("overrun_sat", {24'd0, overrun}, 32'd255);

        // Asynchronous reset at bit 3 of char 5
        @(negedge clk);
        dr = 32'h12345678;
        push_frame(32'h12345678);
        @(posedge clk);
        repeat (217) @(posedge clk);
        #1;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        dr    = 32'h0;
        #1;
        chk("async_txd", {31'd0, txd}, 32'd1);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_overrun", {24'd0, overrun}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bc = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (busy) bc++;
        end
        chk("post_reset_no_frame", bc, 0);

        // Nonzero dr at release sends one frame from the first edge
        do_reset(32'hFFFFFFFF);
        push_frame(32'hFFFFFFFF);
        @(posedge clk);
        #1;
        chk("ff_first_busy", {31'd0, busy}, 32'd1);
        chk("ff_first_txd", {31'd0, txd}, 32'd0);
        wait_done();
        repeat (10) @(posedge clk);
        #1;
        chk("ff_idle_busy", {31'd0, busy}, 32'd0);
        chk("ff_idle_txd", {31'd0, txd}, 32'd1);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
